fwd_hazard_unit: RTL and testbench



---
 rtl/fwd_hazard_unit_if.sv | 29 ++
 rtl/fwd_hazard_unit.sv | 111 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage request / EX-stage forwarding bundle between the pipeline
// control (master) and the forwarding/hazard unit (slave).
interface fwd_hazard_unit_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] ID_Rs;
  logic [REG_W-1:0] ID_Rt;
  logic             ID_UseRs;
  logic             ID_UseRt;
  logic             ID_RegWrite;
  logic [REG_W-1:0] ID_RegDest;
  logic             ID_MemRead;
  logic             Flush;
  logic [1:0]       Forward1;
  logic [1:0]       Forward2;
  logic             Stall;
  logic [CNT_W-1:0] StallCount;

  modport master (
    output ID_Rs, ID_Rt, ID_UseRs, ID_UseRt, ID_RegWrite, ID_RegDest, ID_MemRead, Flush,
    input  Forward1, Forward2, Stall, StallCount
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UseRs, ID_UseRt, ID_RegWrite, ID_RegDest, ID_MemRead, Flush,
    output Forward1, Forward2, Stall, StallCount
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding and load-use hazard detection.
// Keeps a shadow copy of the producers in EX and MEM, issues registered
// operand selects for the instruction entering EX, and requests a single
// stall cycle (with bubble insertion) when a load feeds the next instruction.
// Forward encoding: 00 regfile, 01 EX/MEM ALU result, 10 WB value.
// A WB-stage shadow copy is not kept: a producer reaching WB is covered by
// the mem-stage match made one cycle earlier, so it would never be consulted.
module fwd_hazard_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  fwd_hazard_unit_if.slave   bus
);

  typedef struct packed {
    logic             valid;
    logic             regwrite;
    logic [REG_W-1:0] dest;
    logic             memread;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = stage_t'({(REG_W + 3){1'b0}});
  localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W - 1){1'b0}}, 1'b1};

  stage_t           ex_q, ex_d;
  stage_t           mem_q, mem_d;
  logic [1:0]       fwd1_q, fwd1_d;
  logic [1:0]       fwd2_q, fwd2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_s;
  logic             use_hit_s;

  // Operand select for one source: younger EX producer beats older MEM producer; $0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic             use_src,
    input logic [REG_W-1:0] src,
    input stage_t           ex,
    input stage_t           mem
  );
    logic [1:0] sel;
    if (use_src && (src != REG_ZERO) && ex.valid && ex.regwrite && (ex.dest == src)) begin
      sel = 2'b01;
    end else if (use_src && (src != REG_ZERO) && mem.valid && mem.regwrite && (mem.dest == src)) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Load-use hazard: a load in EX whose destination is read by the ID instruction; Flush overrides.
  always_comb begin
    use_hit_s = (bus.ID_UseRs && (bus.ID_Rs == ex_q.dest)) ||
                (bus.ID_UseRt && (bus.ID_Rt == ex_q.dest));
    stall_s   = ex_q.valid && ex_q.memread && ex_q.regwrite && (ex_q.dest != REG_ZERO) &&
                use_hit_s && !bus.Flush;
  end

  // Next shadow-pipeline contents, forward selects and stall counter.
  always_comb begin
    mem_d  = ex_q;
    ex_d   = STAGE_BUBBLE;
    fwd1_d = 2'b00;
    fwd2_d = 2'b00;
    cnt_d  = cnt_q;
    if (bus.Flush || stall_s) begin
      ex_d   = STAGE_BUBBLE;
      fwd1_d = 2'b00;
      fwd2_d = 2'b00;
    end else begin
      ex_d.valid    = 1'b1;
      ex_d.regwrite = bus.ID_RegWrite;
      ex_d.dest     = bus.ID_RegDest;
      ex_d.memread  = bus.ID_MemRead;
      fwd1_d        = fwd_sel(bus.ID_UseRs, bus.ID_Rs, ex_q, mem_q);
      fwd2_d        = fwd_sel(bus.ID_UseRt, bus.ID_Rt, ex_q, mem_q);
    end
    if (stall_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State update with synchronous reset back to an empty pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q   <= STAGE_BUBBLE;
      mem_q  <= STAGE_BUBBLE;
      fwd1_q <= 2'b00;
      fwd2_q <= 2'b00;
      cnt_q  <= {CNT_W{1'b0}};
    end else begin
      ex_q   <= ex_d;
      mem_q  <= mem_d;
      fwd1_q <= fwd1_d;
      fwd2_q <= fwd2_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.Forward1   = fwd1_q;
  assign bus.Forward2   = fwd2_q;
  assign bus.Stall      = stall_s;
  assign bus.StallCount = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit with a 2-bit stall counter so that
// saturation is reachable. Each step drives one ID instruction, checks the
// combinational Stall before the edge and queues the registered results
// expected after the edge.
module tb_fwd_hazard_unit;

  logic clk;
  logic reset;
  int   tests;
  int   failed;

  typedef struct {
    string      tag;
    logic [1:0] f1;
    logic [1:0] f2;
    logic [1:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  fwd_hazard_unit_if #(.REG_W(5), .CNT_W(2)) bus ();

  fwd_hazard_unit #(.REG_W(5), .CNT_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pop the oldest expectation and compare the registered outputs.
  task automatic check_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      tests++;
      failed++;
      $error("FAIL scoreboard_empty: got no expectation, want one queued");
    end else begin
      e = exp_q.pop_front();
      tests++;
      assert (bus.Forward1 === e.f1) else begin
        failed++;
        $error("FAIL %s Forward1: got %b want %b", e.tag, bus.Forward1, e.f1);
      end
      tests++;
      assert (bus.Forward2 === e.f2) else begin
        failed++;
        $error("FAIL %s Forward2: got %b want %b", e.tag, bus.Forward2, e.f2);
      end
      tests++;
      assert (bus.StallCount === e.cnt) else begin
        failed++;
        $error("FAIL %s StallCount: got %0d want %0d", e.tag, bus.StallCount, e.cnt);
      end
    end
  endtask

  // One cycle: drive ID inputs, check Stall, queue and check post-edge outputs.
  task automatic step(
    input string      tag,
    input logic       rst,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       urs,
    input logic       urt,
    input logic       rw,
    input logic [4:0] dest,
    input logic       mr,
    input logic       fl,
    input logic       exp_stall,
    input logic [1:0] e1,
    input logic [1:0] e2,
    input logic [1:0] ec
  );
    exp_t e;
    @(negedge clk);
    reset           = rst;
    bus.ID_Rs       = rs;
    bus.ID_Rt       = rt;
    bus.ID_UseRs    = urs;
    bus.ID_UseRt    = urt;
    bus.ID_RegWrite = rw;
    bus.ID_RegDest  = dest;
    bus.ID_MemRead  = mr;
    bus.Flush       = fl;
    #1;
    tests++;
    assert (bus.Stall === exp_stall) else begin
      failed++;
      $error("FAIL %s Stall: got %b want %b", tag, bus.Stall, exp_stall);
    end
    e.tag = tag;
    e.f1  = e1;
    e.f2  = e2;
    e.cnt = ec;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  // Directed scenario sequence.
  initial begin
    logic [1:0] c;
    tests  = 0;
    failed = 0;
    reset  = 1'b1;
    bus.ID_Rs = 5'd0; bus.ID_Rt = 5'd0; bus.ID_UseRs = 1'b0; bus.ID_UseRt = 1'b0;
    bus.ID_RegWrite = 1'b0; bus.ID_RegDest = 5'd0; bus.ID_MemRead = 1'b0; bus.Flush = 1'b0;
    @(posedge clk);

    //    tag          rst   rs     rt     urs   urt   rw    dest   mr    fl    stall f1     f2     cnt
    step("reset",      1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd0);

    // Back-to-back ALU dependency.
    step("add3",       1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd3,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd0);
    step("sub_rs3",    1'b0, 5'd3,  5'd7,  1'b1, 1'b1, 1'b1, 5'd10, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'd0);

    // Distance-2 dependency on Rt.
    step("add5",       1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd0);
    step("indep6",     1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd6,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd0);
    step("rt5",        1'b0, 5'd1,  5'd5,  1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'd0);

    // Load-use: one stall, then WB forward.
    step("lw8",        1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd8,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'd0);
    step("use8_stall", 1'b0, 5'd8,  5'd0,  1'b1, 1'b0, 1'b1, 5'd11, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'd1);
    step("use8_go",    1'b0, 5'd8,  5'd0,  1'b1, 1'b0, 1'b1, 5'd11, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'd1);

    // Double match (younger wins) and register 0.
    step("add4_a",     1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd4,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd1);
    step("add4_b",     1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd4,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd1);
    step("use4",       1'b0, 5'd4,  5'd0,  1'b1, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'd1);
    step("use0",       1'b0, 5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd1);
    step("lw0",        1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'd1);
    step("use0_ld",    1'b0, 5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd1);

    // Flush beats a load-use hazard.
    step("lw9",        1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd9,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'd1);
    step("use9_flush", 1'b0, 5'd9,  5'd0,  1'b1, 1'b0, 1'b1, 5'd12, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'd1);
    step("use9_after", 1'b0, 5'd9,  5'd0,  1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'd1);

    // Saturation: five load-use stalls from a fresh reset.
    step("reset2",     1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd0);
    c = 2'd0;
    for (int i = 0; i < 5; i++) begin
      step("sat_lw",   1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd8,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00, c);
      if (c != 2'd3) c = c + 2'd1;
      step("sat_stall",1'b0, 5'd8,  5'd0,  1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 2'b00, 2'b00, c);
      step("sat_go",   1'b0, 5'd8,  5'd0,  1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 2'b10, 2'b00, c);
    end

    // Reset asserted during a stall cycle.
    step("lw8_r",      1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd8,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'd3);
    step("rst_stall",  1'b1, 5'd8,  5'd8,  1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'd0);
    step("post_rst",   1'b0, 5'd8,  5'd8,  1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd0);

    tests++;
    assert (exp_q.size() == 0) else begin
      failed++;
      $error("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
